// File: rtl/bcd_clock_pkg.sv
// Shared BCD digit/time types, digit limits and the time validate/increment helpers
// used by the alarm clock and its alarm channels.
package bcd_clock_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef struct packed {
        bcd_digit_t hh_t;
        bcd_digit_t hh_u;
        bcd_digit_t mm_t;
        bcd_digit_t mm_u;
        bcd_digit_t ss_t;
        bcd_digit_t ss_u;
    } bcd_time_t;

    localparam bcd_digit_t DIGIT_MAX    = 4'd9;
    localparam bcd_digit_t TENS_MAX     = 4'd5;
    localparam int         HOUR_MAX     = 23;
    localparam int         SECS_PER_MIN = 60;

    function automatic int hours_of(bcd_time_t t);
        return int'(t.hh_t) * 10 + int'(t.hh_u);
    endfunction

    function automatic logic time_valid(bcd_time_t t);
        return (t.hh_t <= DIGIT_MAX) && (t.hh_u <= DIGIT_MAX) &&
               (t.mm_t <= TENS_MAX)  && (t.mm_u <= DIGIT_MAX) &&
               (t.ss_t <= TENS_MAX)  && (t.ss_u <= DIGIT_MAX) &&
               (hours_of(t) <= HOUR_MAX);
    endfunction

    // Ripple the carry digit by digit; hours wrap 23 -> 00 as a pair.
    function automatic bcd_time_t time_inc(bcd_time_t t);
        bcd_time_t n;
        n      = t;
        n.ss_u = t.ss_u + 4'd1;
        if (t.ss_u == DIGIT_MAX) begin
            n.ss_u = '0;
            n.ss_t = t.ss_t + 4'd1;
            if (t.ss_t == TENS_MAX) begin
                n.ss_t = '0;
                n.mm_u = t.mm_u + 4'd1;
                if (t.mm_u == DIGIT_MAX) begin
                    n.mm_u = '0;
                    n.mm_t = t.mm_t + 4'd1;
                    if (t.mm_t == TENS_MAX) begin
                        n.mm_t = '0;
                        if (hours_of(t) == HOUR_MAX) begin
                            n.hh_t = '0;
                            n.hh_u = '0;
                        end else if (t.hh_u == DIGIT_MAX) begin
                            n.hh_u = '0;
                            n.hh_t = t.hh_t + 4'd1;
                        end else begin
                            n.hh_u = t.hh_u + 4'd1;
                        end
                    end
                end
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_alarm_chan.sv
// One alarm channel: hh:mm match on the new time, ring timer with auto-clear,
// and (with BCD_CLOCK_SNOOZE_EN) a snooze re-ring timer.
module bcd_alarm_chan
    import bcd_clock_pkg::*;
#(
    parameter int RING_SECS  = 60,
    parameter int SNOOZE_MIN = 5
) (
    input  logic        ck,
    input  logic        rs,
    input  logic        tick,
    input  logic        sec_zero,
    input  logic [15:0] now_hhmm,
    input  logic [15:0] alarm_hhmm,
    input  logic        en,
    input  logic        ack,
    input  logic        snooze,
    output logic        ring
);

    localparam logic [7:0] RING_LAST = 8'(RING_SECS - 1);

    logic       ring_d, ring_q;
    logic [7:0] ring_cnt_d, ring_cnt_q;
    logic       trig, rering, snooze_clr;

    assign trig = tick && sec_zero && en && (now_hhmm == alarm_hhmm);

`ifdef BCD_CLOCK_SNOOZE_EN
    localparam logic [11:0] SNZ_LAST = 12'(SNOOZE_MIN * SECS_PER_MIN - 1);

    logic        snz_pend_d, snz_pend_q;
    logic [11:0] snz_cnt_d, snz_cnt_q;

    assign snooze_clr = snooze;

    always_comb begin
        snz_pend_d = snz_pend_q;
        snz_cnt_d  = snz_cnt_q;
        rering     = 1'b0;
        if (ack) begin
            snz_pend_d = 1'b0;
            snz_cnt_d  = '0;
        end else if (snooze && ring_q) begin
            snz_pend_d = 1'b1;
            snz_cnt_d  = '0;
        end else if (snz_pend_q && tick) begin
            if (snz_cnt_q == SNZ_LAST) begin
                snz_pend_d = 1'b0;
                snz_cnt_d  = '0;
                rering     = 1'b1;
            end else begin
                snz_cnt_d = snz_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge ck or negedge rs) begin
        if (!rs) begin
            snz_pend_q <= 1'b0;
            snz_cnt_q  <= '0;
        end else begin
            snz_pend_q <= snz_pend_d;
            snz_cnt_q  <= snz_cnt_d;
        end
    end
`else
    logic unused_snooze;

    assign snooze_clr    = 1'b0;
    assign rering        = 1'b0;
    assign unused_snooze = snooze ^ (SNOOZE_MIN == 0);
`endif

    // ack and a dropped enable outrank any trigger in the same cycle.
    always_comb begin
        ring_d     = ring_q;
        ring_cnt_d = ring_cnt_q;
        if (ack || !en) begin
            ring_d     = 1'b0;
            ring_cnt_d = '0;
        end else if (ring_q) begin
            if (snooze_clr || (tick && ring_cnt_q == RING_LAST)) begin
                ring_d     = 1'b0;
                ring_cnt_d = '0;
            end else if (tick) begin
                ring_cnt_d = ring_cnt_q + 1'b1;
            end
        end else if (trig || rering) begin
            ring_d     = 1'b1;
            ring_cnt_d = '0;
        end
    end

    always_ff @(posedge ck or negedge rs) begin
        if (!rs) begin
            ring_q     <= 1'b0;
            ring_cnt_q <= '0;
        end else begin
            ring_q     <= ring_d;
            ring_cnt_q <= ring_cnt_d;
        end
    end

    assign ring = ring_q;

endmodule

// File: rtl/bcd_alarm_clock.sv
// BCD 24-hour clock with prescaler, validated time load and N_ALARM alarm channels.
// Optional snooze support is built only when BCD_CLOCK_SNOOZE_EN is defined.
module bcd_alarm_clock
    import bcd_clock_pkg::*;
#(
    parameter int TICK_DIV   = 50000000,
    parameter int N_ALARM    = 4,
    parameter int RING_SECS  = 60,
    parameter int SNOOZE_MIN = 5
) (
    input  logic                   ck,
    input  logic                   rs,
    input  logic                   run,
    input  logic                   set_valid,
    input  logic [23:0]            set_time,
    input  logic [N_ALARM-1:0]     alarm_en,
    input  logic [16*N_ALARM-1:0]  alarm_time,
    input  logic [N_ALARM-1:0]     ack,
    input  logic                   snooze,
    output logic [23:0]            time_bcd,
    output logic                   sec_pulse,
    output logic                   set_err,
    output logic [N_ALARM-1:0]     ring,
    output logic                   ring_any
);

    localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre_d, pre_q;
    bcd_time_t     time_d, time_q, time_next;
    logic          sec_pulse_d, sec_pulse_q;
    logic          set_err_d, set_err_q;
    logic          tick, load_ok, tick_applied;
    logic [15:0]   now_hhmm;
    logic          sec_zero;

    assign tick         = run && (pre_q == TICK_LAST);
    assign load_ok      = set_valid && time_valid(set_time);
    assign tick_applied = tick && !load_ok;
    assign time_next    = time_inc(time_q);
    assign now_hhmm     = time_next[23:8];
    assign sec_zero     = (time_next[7:0] == 8'h00);

    // NOTE: every signal gets a default first so no path through the block infers a latch.
    always_comb begin
        pre_d       = pre_q;
        time_d      = time_q;
        sec_pulse_d = tick_applied;
        set_err_d   = set_valid && !load_ok;
        if (run) begin
            pre_d = tick ? '0 : pre_q + 1'b1;
        end
        if (tick_applied) begin
            time_d = time_next;
        end
        if (load_ok) begin
            time_d = set_time;
            pre_d  = '0;
        end
    end

    // NOTE: state updates use <= so every flop samples the pre-edge values of the others.
    always_ff @(posedge ck or negedge rs) begin
        if (!rs) begin
            pre_q       <= '0;
            time_q      <= '0;
            sec_pulse_q <= 1'b0;
            set_err_q   <= 1'b0;
        end else begin
            pre_q       <= pre_d;
            time_q      <= time_d;
            sec_pulse_q <= sec_pulse_d;
            set_err_q   <= set_err_d;
        end
    end

    for (genvar i = 0; i < N_ALARM; i++) begin : g_chan
        bcd_alarm_chan #(
            .RING_SECS  (RING_SECS),
            .SNOOZE_MIN (SNOOZE_MIN)
        ) u_chan (
            .ck         (ck),
            .rs         (rs),
            .tick       (tick_applied),
            .sec_zero   (sec_zero),
            .now_hhmm   (now_hhmm),
            .alarm_hhmm (alarm_time[16*i +: 16]),
            .en         (alarm_en[i]),
            .ack        (ack[i]),
            .snooze     (snooze),
            .ring       (ring[i])
        );
    end

    assign time_bcd  = time_q;
    assign sec_pulse = sec_pulse_q;
    assign set_err   = set_err_q;
    assign ring_any  = |ring;

endmodule

// File: doc/bcd_alarm_clock.md
BCD_ALARM_CLOCK -- requirements
Module: bcd_alarm_clock

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000, ck cycles per second tick (legal: 1 or more).
REQ-002 SHALL have parameter N_ALARM, default 4, number of independent alarm channels (legal: 1 to 8).
REQ-003 SHALL have parameter RING_SECS, default 60, seconds an alarm rings before auto-clear (legal: 1 to 255).
REQ-004 SHALL have parameter SNOOZE_MIN, default 5, snooze delay in minutes (legal: 1 to 59; used only with BCD_CLOCK_SNOOZE_EN).
REQ-005 SHALL have port ck, input, 1, the single clock.
REQ-006 SHALL have port rs, input, 1, reset: asynchronous, active-low.
REQ-007 SHALL have port run, input, 1, time advance enable.
REQ-008 SHALL have port set_valid, input, 1, one-cycle time load strobe.
REQ-009 SHALL have port set_time, input, 24, load value in BCD {hh_t,hh_u,mm_t,mm_u,ss_t,ss_u}.
REQ-010 SHALL have port alarm_en, input, N_ALARM, per-channel alarm enable.
REQ-011 SHALL have port alarm_time, input, 16*N_ALARM, per-channel BCD hh:mm; channel i occupies [16i+15:16i].
REQ-012 SHALL have port ack, input, N_ALARM, per-channel ring clear.
REQ-013 SHALL have port snooze, input, 1, snooze request.
REQ-014 SHALL have port time_bcd, output, 24, current time in the same layout as set_time.
REQ-015 SHALL have port sec_pulse, output, 1, one-cycle pulse on each applied tick.
REQ-016 SHALL have port set_err, output, 1, one-cycle pulse when a load is rejected.
REQ-017 SHALL have port ring, output, N_ALARM, per-channel ringing flag.
REQ-018 SHALL have port ring_any, output, 1, OR of ring.

Function
REQ-019 The prescaler SHALL count 0 to TICK_DIV-1 while run=1 and raise the internal tick in the cycle it equals TICK_DIV-1, then wrap to 0; with TICK_DIV=1 a tick SHALL occur every run=1 cycle.
REQ-020 While run=0 the prescaler, time, ring timers and snooze timers SHALL hold; ack and set_valid SHALL still act.
REQ-021 On each tick the time SHALL advance one second with BCD carries: ss_u 9->0, ss_t 5->0, mm_u 9->0, mm_t 5->0, hours 23->00; 23:59:59 SHALL become 00:00:00.
REQ-022 sec_pulse SHALL be 1 in the cycle after the tick, coincident with the updated time_bcd.
REQ-023 The time load SHALL be accepted only when every digit is at most 9, ss_t and mm_t are at most 5, and hh is at most 23.
REQ-024 An accepted load SHALL take effect at the next edge and clear the prescaler; it SHALL override a same-cycle tick, and no sec_pulse SHALL follow it.
REQ-025 A rejected load SHALL leave the time unchanged and pulse set_err one cycle later.
REQ-026 A tick SHALL trigger channel i when the new time has ss=00, hh:mm equals alarm_time[i], and alarm_en[i]=1; ring[i] SHALL then rise together with sec_pulse.
REQ-027 Loading a time that equals an alarm SHALL NOT trigger that alarm.
REQ-028 A ringing channel SHALL count RING_SECS ticks and then clear; a trigger arriving while it rings SHALL be ignored.
REQ-029 ring[i] SHALL clear at the next edge when ack[i]=1 or alarm_en[i]=0; if ack and a trigger coincide, ack SHALL win.
REQ-030 Channels SHALL be fully independent; ring_any SHALL be combinational OR of ring.

Reset
REQ-031 While rs=0: time_bcd=000000, prescaler=0, ring=0, sec_pulse=0, set_err=0, snooze timers cleared; reset mid-ring SHALL clear the ring with no re-trigger after release.

Configuration
REQ-032 With BCD_CLOCK_SNOOZE_EN defined, snooze=1 SHALL clear all ringing channels and arm each of them to re-ring after SNOOZE_MIN*60 ticks (re-ring subject to alarm_en); ack[i] SHALL cancel a pending snooze on channel i.
REQ-033 Without BCD_CLOCK_SNOOZE_EN, snooze SHALL be ignored and no snooze timer logic SHALL be built.

Structure
REQ-034 Package bcd_clock_pkg SHALL hold the BCD digit type, the time record type (six digits), digit limits (9, 5, 23), and the seconds-per-minute constant.
REQ-035 Each alarm channel SHALL be one instance of sub-module bcd_alarm_chan (match, ring timer, optional snooze timer), generated N_ALARM times.

Verification
REQ-036 Carry test: TICK_DIV=4, load 23:59:58, run=1 -> after 2 ticks time_bcd=000000; sec_pulse spaced 4 cycles apart.
REQ-037 Load rejection: set_time=0x246000 -> set_err pulses once and time is unchanged; set_time=0x235959 -> accepted.
REQ-038 Alarm trigger: alarm0=0x0700, en=1, load 06:59:59 -> ring[0]=1 with the next sec_pulse; auto-clears after RING_SECS ticks.
REQ-039 Ack priority: ack[0] asserted on the trigger cycle -> ring[0] stays 0; a second channel with the same time rings independently.
REQ-040 Reset mid-operation: rs=0 while ring[1]=1 and the prescaler is mid-count -> all outputs 0 asynchronously; after release the first tick arrives TICK_DIV cycles later.
REQ-041 With BCD_CLOCK_SNOOZE_EN and SNOOZE_MIN=1: snooze while ringing -> ring clears and rises again after exactly 60 ticks.
